// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipes (package)
// Description : Shared types, opcode/funct constants and immediate builder
//               for the decode queue. RV64M constants exist only when
//               DECODE_MULDIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package pipes;

  typedef logic [31:0] u32;
  typedef logic [63:0] word_t;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9
`ifdef DECODE_MULDIV_EN
    ,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
`endif
  } aluop_t;

  typedef struct packed {
    aluop_t aluop;
    logic   reg_write;
    logic   alusrc;
    logic   is_word;
    logic   mem_read;
    logic   mem_write;
    logic   branch;
    logic   jump;
  } control_t;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_fmt_t;

  typedef struct packed {
    word_t    pc;
    word_t    imm;
    control_t ctl;
    logic     illegal;
  } decoded_t;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef DECODE_MULDIV_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
`endif

  // Register/immediate ALU op selected by funct3 (SUB/SRA resolved by caller)
  function automatic aluop_t base_aluop(input logic [2:0] f3);
    case (f3)
      F3_ADD_SUB: return ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

  // Word (*W) forms only exist for add/sub and the shifts
  function automatic logic word_f3_ok(input logic [2:0] f3);
    return (f3 == F3_ADD_SUB) || (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

`ifdef DECODE_MULDIV_EN
  function automatic aluop_t muldiv_aluop(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction
`endif

  // Assemble the format-specific immediate, sign-extended from instr[31]
  function automatic word_t build_imm(input imm_fmt_t fmt, input u32 instr);
    word_t imm;
    case (fmt)
      IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue_if
// Description : Fetch-side enqueue and execute-side dequeue handshake bundle,
//               plus the pipeline flush request.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_queue_if;
  import pipes::*;

  logic     flush;
  logic     in_valid;
  logic     in_ready;
  u32       in_instr;
  word_t    in_pc;
  logic     out_valid;
  logic     out_ready;
  word_t    out_pc;
  word_t    out_imm;
  control_t out_ctl;
  logic     out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_ctl, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_ctl, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/decode_queue_decode_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_unit
// Description : Combinational RV64I decoder (RV64M when DECODE_MULDIV_EN is
//               defined). Produces imm/ctl/illegal; the pc field is left 0.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_unit
  import pipes::*;
(
  input  u32       instr,
  output decoded_t dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_word_op;
  logic [6:0] w_shift_hi;
  control_t   w_ctl;
  imm_fmt_t   w_fmt;
  logic       w_bad;

  assign w_opcode  = instr[6:0];
  assign w_funct3  = instr[14:12];
  assign w_funct7  = instr[31:25];
  assign w_word_op = (w_opcode == OPC_OP_32) || (w_opcode == OPC_OP_IMM_32);
  // Bits above the shamt: 6-bit shamt for 64-bit ops, 5-bit for word ops
  assign w_shift_hi = w_word_op ? instr[31:25] : {instr[31:26], 1'b0};

  // Classify opcode/funct fields into control signals and immediate format
  always_comb begin
    w_ctl = '0;
    w_fmt = IMM_NONE;
    w_bad = 1'b0;
    case (w_opcode)
      OPC_OP, OPC_OP_32: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.is_word   = w_word_op;
        case (w_funct7)
          F7_BASE: begin
            w_ctl.aluop = base_aluop(w_funct3);
            if (w_word_op && !word_f3_ok(w_funct3)) w_bad = 1'b1;
          end
          F7_ALT: begin
            if (w_funct3 == F3_ADD_SUB)      w_ctl.aluop = ALU_SUB;
            else if (w_funct3 == F3_SRL_SRA) w_ctl.aluop = ALU_SRA;
            else                             w_bad = 1'b1;
          end
`ifdef DECODE_MULDIV_EN
          F7_MULDIV: begin
            w_ctl.aluop = muldiv_aluop(w_funct3);
            // MULW/DIVW/DIVUW/REMW/REMUW only; no high-half word forms
            if (w_word_op && (w_funct3 != 3'b000) && !w_funct3[2]) w_bad = 1'b1;
          end
`endif
          default: w_bad = 1'b1;
        endcase
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        w_fmt           = IMM_I;
        w_ctl.reg_write = 1'b1;
        w_ctl.alusrc    = 1'b1;
        w_ctl.is_word   = w_word_op;
        w_ctl.aluop     = base_aluop(w_funct3);
        if (w_word_op && !word_f3_ok(w_funct3)) w_bad = 1'b1;
        if (w_funct3 == F3_SLL && w_shift_hi != 7'b0) w_bad = 1'b1;
        if (w_funct3 == F3_SRL_SRA) begin
          if (instr[30]) w_ctl.aluop = ALU_SRA;
          if ({w_shift_hi[6], w_shift_hi[4:0]} != 6'b0) w_bad = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        w_fmt           = IMM_U;
        w_ctl.reg_write = 1'b1;
        w_ctl.alusrc    = 1'b1;
      end
      OPC_JAL: begin
        w_fmt           = IMM_J;
        w_ctl.reg_write = 1'b1;
        w_ctl.jump      = 1'b1;
      end
      OPC_JALR: begin
        w_fmt           = IMM_I;
        w_ctl.reg_write = 1'b1;
        w_ctl.alusrc    = 1'b1;
        w_ctl.jump      = 1'b1;
        if (w_funct3 != 3'b000) w_bad = 1'b1;
      end
      OPC_BRANCH: begin
        w_fmt        = IMM_B;
        w_ctl.branch = 1'b1;
        case (w_funct3[2:1])
          2'b00:   w_ctl.aluop = ALU_SUB;
          2'b10:   w_ctl.aluop = ALU_SLT;
          2'b11:   w_ctl.aluop = ALU_SLTU;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_fmt           = IMM_I;
        w_ctl.reg_write = 1'b1;
        w_ctl.alusrc    = 1'b1;
        w_ctl.mem_read  = 1'b1;
        if (w_funct3 == 3'b111) w_bad = 1'b1;
      end
      OPC_STORE: begin
        w_fmt           = IMM_S;
        w_ctl.alusrc    = 1'b1;
        w_ctl.mem_write = 1'b1;
        if (w_funct3[2]) w_bad = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Illegal encodings carry a zeroed payload so execute sees a clean bubble
  always_comb begin
    dec = '0;
    if (w_bad || instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      dec.imm = build_imm(w_fmt, instr);
      dec.ctl = w_ctl;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : Decode-at-enqueue circular queue between fetch and execute.
//               Optional RV64M decode enabled by defining DECODE_MULDIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_queue
  import pipes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  decode_queue_if.slave q
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  decoded_t             r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_enq;
  logic                 w_deq;
  decoded_t             w_dec;
  decoded_t             w_entry;
  decoded_t             w_head;

  decode_unit u_decode (
    .instr (q.in_instr),
    .dec   (w_dec)
  );

  // Attach the fetch PC to the decoded payload
  always_comb begin
    w_entry    = w_dec;
    w_entry.pc = q.in_pc;
  end

  assign w_full      = (r_count == c_cnt_w'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign q.in_ready  = !w_full;
  assign q.out_valid = !w_empty;
  // Full blocks enqueue even when a dequeue frees a slot this cycle
  assign w_enq = q.in_valid && !w_full && !q.flush;
  assign w_deq = !w_empty && q.out_ready && !q.flush;

  // Pointer and occupancy bookkeeping; flush drops any same-cycle transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (q.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
      else if (w_deq && !w_enq) r_count <= r_count - 1'b1;
    end
  end

  // Payload storage; contents are only observed through the gated head
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_entry;
  end

  // Head outputs read straight from storage, zeroed while the queue is empty
  always_comb begin
    w_head = w_empty ? '0 : r_mem[r_rd_ptr];
  end

  assign q.out_pc      = w_head.pc;
  assign q.out_imm     = w_head.imm;
  assign q.out_ctl     = w_head.ctl;
  assign q.out_illegal = w_head.illegal;

endmodule
`default_nettype wire

// File: doc/decode_queue.md
# decode_queue

Buffered, parametrised instruction decode stage. It takes raw 32-bit instructions from fetch, decodes each one once at enqueue, and stores the result in a DEPTH-entry circular queue. Decoded entries are presented to execute under a valid/ready handshake. It decouples fetch from execute stalls, supports pipeline flush, and extends the ALU-only decode to all RV64I immediate formats, loads/stores, branches/jumps, shifts, compares and illegal-instruction detection.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all entries; overrides enqueue in the same cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept; equals !full
- in_instr  in  32  raw instruction (u32)
- in_pc  in  64  PC of in_instr
- out_valid  out  1  head entry valid; equals !empty
- out_ready  in  1  execute consumes head
- out_pc  out  64  head PC
- out_imm  out  64  head sign-extended immediate (word_t)
- out_ctl  out  control_t  head control bundle
- out_illegal  out  1  head entry is an undecodable instruction
- Reset: asynchronous, active-high, on `reset`; single clock `clk`.

## Operation
- Enqueue fires when in_valid && in_ready && !flush. The instruction is decoded combinationally and the {pc, imm, ctl, illegal} result is written at wr_ptr. wr_ptr then increments.
- Dequeue fires when out_valid && out_ready && !flush. rd_ptr then increments.
- Outputs are driven from the entry at rd_ptr, so there is no enqueue→output bypass.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH+1) bits: +1 on enqueue only, −1 on dequeue only, unchanged when both fire.
- Full: count==DEPTH. In this state in_ready=0, even if a dequeue fires the same cycle.
- Empty: count==0. In this state out_valid=0 and out_ready is ignored.
- Flush: rd_ptr, wr_ptr and count clear to 0 on the next edge. Any in-flight enqueue and dequeue in that cycle are dropped.
- Decode coverage:
  - OP and OP-32: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - OP-IMM and OP-IMM-32: the same operations with immediate operand. Shamt is 6 bits for OP-IMM and 5 bits for OP-IMM-32.
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE.
- Immediates are built per format and sign-extended from bit 31 to 64 bits:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- ctl fields set per instruction: aluop, reg_write, alusrc, is_word, mem_read, mem_write, branch, jump. Every field is explicitly defaulted, so there are no latches.
- Illegal instruction: unknown opcode, unknown funct3/funct7 combination, or instr[1:0]≠2'b11. The entry is still enqueued with ctl='0, imm='0 and illegal=1.

## Timing
- Reset values: in_ready=1, out_valid=0, out_pc=0, out_imm=0, out_ctl='0, out_illegal=0. Pointers and count are 0.
- Latency: enqueue at edge N makes the entry visible with out_valid=1 after edge N, at the earliest.
- Throughput: 1 instruction per cycle sustained while not full and out_ready=1.
- Payload outputs are don't-care while out_valid=0. The bench checks them only when out_valid=1.
- Reset asserted mid-operation empties the queue immediately, asynchronously.

## Configuration
- DECODE_MULDIV_EN defined: OP and OP-32 with funct7=7'b0000001 decode as RV64M instructions, using aluop ALU_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants, with reg_write=1.
- DECODE_MULDIV_EN undefined: those encodings set illegal=1.

## Structure
- Package pipes holds:
  - control_t, extended with mem_read, mem_write, branch and jump.
  - imm_fmt_t enum: I, S, B, U, J, NONE.
  - decoded_t struct: pc, imm, ctl, illegal.
  - New opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE.
  - New funct3/funct7 and aluop constants, including the RV64M constants under the macro.
- Sub-module decode_unit: purely combinational, u32 in → decoded_t out (without pc). Instantiated once, at the write port.

## Test plan
- Reset, then enqueue addi x1,x0,-1 (0xFFF00093): next cycle out_valid=1, out_imm=0xFFFF_FFFF_FFFF_FFFF, aluop=ALU_ADD, alusrc=1, reg_write=1.
- Enqueue with out_ready=0: after DEPTH enqueues, in_ready=0. Assert out_ready=1 and in_valid=1 together: first cycle dequeue only, in_ready=1 afterwards, entries emerge in FIFO order with correct PCs across pointer wrap.
- Stream sw x2,-4(x1), beq x0,x0,-8 and jal x0,2048: imm respectively 0xFFFF…FFFC, 0xFFFF…FFF8 and 0x800; ctl.mem_write, ctl.branch and ctl.jump set respectively.
- Fill to 3 entries, then assert flush with in_valid=1 in the same cycle: next cycle out_valid=0 and count=0, and the new instruction is dropped.
- Enqueue 0x0000_0000 and mul x3,x1,x2 (0x022081B3): first gives out_illegal=1 and ctl='0. Second gives ALU_MUL with DECODE_MULDIV_EN defined, out_illegal=1 without.
- Assert reset asynchronously with 2 entries queued: out_valid drops before the next clk edge and in_ready=1.
